id_ex_pipe_reg: RTL

- Parametrised ID/EX pipeline register. Successor to the single-bit lw control flop: it carries the full control bundle, both operands, the immediate and the register addresses from ID to EX.
- Adds a valid bit, stall (hold), flush (bubble insert), load-use hazard detection with automatic bubble insertion, and a saturating bubble counter.
- Sits between the decode stage and the ALU/EX stage. The hazard output also freezes PC and the IF/ID register upstream.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 22 ++
 rtl/id_ex_pipe_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths, control-bundle bit
// positions and the ID/EX payload layout used by neighbouring stages.
package pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;

  localparam int LW_BIT       = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int REGWRITE_BIT = 2;
  localparam int MEMTOREG_BIT = 3;
  localparam int ALUSRC_BIT   = 4;
  localparam int BRANCH_BIT   = 5;
  localparam int ALUOP_LSB    = 6;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } id_ex_bundle_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction waiting in ID. Register $0 is never a real dependency.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  ex_lw,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_valid,
  input  logic                  stall,
  output logic                  hazard
);

  logic addr_match;

  assign addr_match = (ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr);
  assign hazard     = ex_lw && (ex_rt_addr != '0) && addr_match && id_valid && !stall;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control, automatic
// load-use bubble insertion and a saturating count of inserted bubbles.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int CTRL_W     = pipe_pkg::CTRL_W,
  parameter int LW_BIT     = pipe_pkg::LW_BIT,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  count_clr,
  output logic                  ex_valid,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs_addr,
  output logic [REG_ADDR_W-1:0] ex_rt_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_lw,
  output logic                  load_use_hazard,
  output logic [CNT_W-1:0]      bubble_count
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } payload_t;

  payload_t id_payload;
  payload_t ex_payload;
  logic     ex_valid_q;
  logic     count_bubble;

  // An invalid ID slot still moves its fields, but never its control bits.
  assign id_payload = '{
    ctrl:    id_valid ? id_ctrl : '0,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     id_imm,
    rs_addr: id_rs_addr,
    rt_addr: id_rt_addr,
    rd_addr: id_rd_addr
  };

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_lw      (ex_lw),
    .ex_rt_addr (ex_payload.rt_addr),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_valid   (id_valid),
    .stall      (stall),
    .hazard     (load_use_hazard)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_payload <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
      ex_payload <= '0;
    end else if (stall) begin
      ex_valid_q <= ex_valid_q;
      ex_payload <= ex_payload;
    end else if (load_use_hazard) begin
      ex_valid_q <= 1'b0;
      ex_payload <= '0;
    end else begin
      ex_valid_q <= id_valid;
      ex_payload <= id_payload;
    end
  end

  // Flushing an already-empty stage displaces nothing, so it is not a bubble.
  assign count_bubble = (flush && (ex_valid_q || id_valid)) || (!flush && load_use_hazard);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count <= '0;
    end else if (count_clr) begin
      bubble_count <= '0;
    end else if (count_bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_payload.ctrl;
  assign ex_rs_data = ex_payload.rs_data;
  assign ex_rt_data = ex_payload.rt_data;
  assign ex_imm     = ex_payload.imm;
  assign ex_rs_addr = ex_payload.rs_addr;
  assign ex_rt_addr = ex_payload.rt_addr;
  assign ex_rd_addr = ex_payload.rd_addr;
  assign ex_lw      = ex_valid_q && ex_payload.ctrl[LW_BIT];

endmodule
